// File: rtl/bottom_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// bottom_mem_arbiter_if
// Bundle of every signal between the bottom-memory arbiter, its two
// requesters and the single-port 32K x 20-bit bottom memory.
//
//   p0_* : instruction-fetch port  (req/we/addr/wdata in, gnt/rvalid out)
//   p1_* : load/store port         (req/we/addr/wdata in, gnt/rvalid out)
//   rdata                          shared read data returned to both ports
//   mem_addr/mem_di/mem_we/mem_re  control lines driven to the memory
//   mem_do                         registered memory output (1-cycle latency)
//
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (requesters plus memory)
// ---------------------------------------------------------------------------
interface bottom_mem_arbiter_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 15
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_do;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_do,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
    output rdata, mem_addr, mem_di, mem_we, mem_re
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_do,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
    input  rdata, mem_addr, mem_di, mem_we, mem_re
  );
endinterface

// File: rtl/bottom_mem_arbiter.sv
// ---------------------------------------------------------------------------
// bottom_mem_arbiter
// Two-port arbiter in front of the single-port bottom memory. Port 0 is
// instruction fetch, port 1 the load/store unit. At most one access is
// granted per cycle; the grant and all memory control lines are
// combinational from the requests and a one-bit last-winner pointer.
// Read data comes back one cycle after the grant on the shared rdata bus,
// qualified by a single-cycle per-port rvalid pulse.
//
// Parameters:
//   DATA_W : memory word width
//   ADDR_W : memory address width
//   RR_EN  : 1 = round-robin on contention, 0 = port 0 always wins
//
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : bottom_mem_arbiter_if.slave (requester and memory signals)
// ---------------------------------------------------------------------------
module bottom_mem_arbiter #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 15,
  parameter int RR_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bottom_mem_arbiter_if.slave  bus
);

  // Last-winner pointer: 1 means port 1 won the most recent grant.
  logic last_win;

  logic gnt0;
  logic gnt1;
  logic gnt_any;
  logic sel_we;

  // Read-return stage: a read granted at one edge is answered in the
  // following cycle, when the memory presents its registered output.
  logic vld_p1;
  logic port_p1;

  // ---- stage 0: arbitration and memory drive (combinational) ----
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
        if (RR_EN != 0) begin
          // Contention goes to whichever port did not win last time.
          gnt0 = last_win;
          gnt1 = ~last_win;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign sel_we  = gnt1 ? bus.p1_we : bus.p0_we;

  assign bus.p0_gnt   = gnt0;
  assign bus.p1_gnt   = gnt1;

  // Without a grant the port 0 fields pass through; they are don't-care
  // because both strobes are low.
  assign bus.mem_addr = gnt1 ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_di   = gnt1 ? bus.p1_wdata : bus.p0_wdata;
  assign bus.mem_we   = gnt_any &  sel_we;
  assign bus.mem_re   = gnt_any & ~sel_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_win <= 1'b1;
    end else if (gnt_any) begin
      last_win <= gnt1;
    end
  end

  // ---- stage 1: read return ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      // Reloaded every cycle so rvalid is a one-cycle pulse per read.
      vld_p1 <= gnt_any & ~sel_we;
    end
  end

  always_ff @(posedge clk) begin
    port_p1 <= gnt1;
  end

  // A return still pending when reset arrives is suppressed immediately.
  assign bus.p0_rvalid = vld_p1 & ~port_p1 & ~rst;
  assign bus.p1_rvalid = vld_p1 &  port_p1 & ~rst;
  assign bus.rdata     = bus.mem_do;

endmodule

// File: tb/tb_bottom_mem_arbiter.sv
module tb_bottom_mem_arbiter;
  localparam int DW = 20;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus per DUT (0 = round-robin, 1 = fixed priority) and per port.
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];

  bottom_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rr ();
  bottom_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fp ();

  bottom_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_rr.slave));
  bottom_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp.slave));

  assign bus_rr.p0_req = req[0][0];   assign bus_rr.p1_req = req[0][1];
  assign bus_rr.p0_we  = we[0][0];    assign bus_rr.p1_we  = we[0][1];
  assign bus_rr.p0_addr = addr[0][0]; assign bus_rr.p1_addr = addr[0][1];
  assign bus_rr.p0_wdata = wdata[0][0]; assign bus_rr.p1_wdata = wdata[0][1];
  assign bus_fp.p0_req = req[1][0];   assign bus_fp.p1_req = req[1][1];
  assign bus_fp.p0_we  = we[1][0];    assign bus_fp.p1_we  = we[1][1];
  assign bus_fp.p0_addr = addr[1][0]; assign bus_fp.p1_addr = addr[1][1];
  assign bus_fp.p0_wdata = wdata[1][0]; assign bus_fp.p1_wdata = wdata[1][1];

  // Environment: two single-port memories with registered output.
  bit [DW-1:0] env_mem [2][32768];
  bit [DW-1:0] env_do  [2];
  always @(posedge clk) begin
    if (bus_rr.mem_we) env_mem[0][bus_rr.mem_addr] <= bus_rr.mem_di;
    if (bus_rr.mem_re) env_do[0] <= env_mem[0][bus_rr.mem_addr];
    if (bus_fp.mem_we) env_mem[1][bus_fp.mem_addr] <= bus_fp.mem_di;
    if (bus_fp.mem_re) env_do[1] <= env_mem[1][bus_fp.mem_addr];
  end
  assign bus_rr.mem_do = env_do[0];
  assign bus_fp.mem_do = env_do[1];

  // Observed outputs gathered per DUT.
  logic [5:0]    o_flags [2];
  logic [AW-1:0] o_maddr [2];
  logic [DW-1:0] o_mdi   [2];
  logic [DW-1:0] o_rdata [2];
  assign o_flags[0] = {bus_rr.p0_gnt, bus_rr.p1_gnt, bus_rr.p0_rvalid, bus_rr.p1_rvalid,
                       bus_rr.mem_we, bus_rr.mem_re};
  assign o_flags[1] = {bus_fp.p0_gnt, bus_fp.p1_gnt, bus_fp.p0_rvalid, bus_fp.p1_rvalid,
                       bus_fp.mem_we, bus_fp.mem_re};
  assign o_maddr[0] = bus_rr.mem_addr; assign o_maddr[1] = bus_fp.mem_addr;
  assign o_mdi[0]   = bus_rr.mem_di;   assign o_mdi[1]   = bus_fp.mem_di;
  assign o_rdata[0] = bus_rr.rdata;    assign o_rdata[1] = bus_fp.rdata;

  // Reference model: which port served last, a reference memory, and the
  // read answer owed in the next cycle.
  int          m_last  [2];
  bit          m_rv    [2];
  int          m_rport [2];
  bit [DW-1:0] m_rdata [2];
  bit [DW-1:0] ref_mem [2][32768];

  // Expectations and captures of the current cycle.
  bit          e_any [2];
  int          e_win [2];
  bit          e_rv  [2];
  bit          e_wr  [2];
  logic [60:0] e_full [2];
  logic [60:0] o_full [2];
  logic [5:0]  c_flags [2];
  logic [DW-1:0] c_rdata [2];

  task automatic predict();
    for (int d = 0; d < 2; d++) begin
      bit any;
      int win;
      bit [5:0] fl;
      any = 1'b0;
      win = 0;
      if (!rst) begin
        if (req[d][0] && req[d][1]) begin
          any = 1'b1;
          win = (d == 0) ? 1 - m_last[d] : 0;
        end else if (req[d][0]) begin
          any = 1'b1; win = 0;
        end else if (req[d][1]) begin
          any = 1'b1; win = 1;
        end
      end
      e_any[d] = any;
      e_win[d] = win;
      e_rv[d]  = !rst && m_rv[d];
      e_wr[d]  = any && we[d][win];
      fl = {any && win == 0, any && win == 1,
            e_rv[d] && m_rport[d] == 0, e_rv[d] && m_rport[d] == 1,
            any && we[d][win], any && !we[d][win]};
      e_full[d] = {fl, any ? addr[d][win] : {AW{1'b0}},
                   e_wr[d] ? wdata[d][win] : {DW{1'b0}},
                   e_rv[d] ? m_rdata[d] : {DW{1'b0}}};
    end
  endtask

  task automatic commit();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_last[d] = 1;
        m_rv[d]   = 1'b0;
      end else begin
        m_rv[d] = e_any[d] && !e_wr[d];
        if (e_any[d]) begin
          m_last[d] = e_win[d];
          if (e_wr[d]) begin
            ref_mem[d][addr[d][e_win[d]]] = wdata[d][e_win[d]];
          end else begin
            m_rport[d] = e_win[d];
            m_rdata[d] = ref_mem[d][addr[d][e_win[d]]];
          end
        end
      end
    end
  endtask

  // One clock cycle: predict, sample at negedge, commit at posedge.
  task automatic advance();
    predict();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      c_flags[d] = o_flags[d];
      c_rdata[d] = o_rdata[d];
      o_full[d] = {o_flags[d], e_any[d] ? o_maddr[d] : {AW{1'b0}},
                   e_wr[d] ? o_mdi[d] : {DW{1'b0}},
                   e_rv[d] ? o_rdata[d] : {DW{1'b0}}};
    end
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drive(input int p, input logic rq, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    for (int d = 0; d < 2; d++) begin
      req[d][p] = rq; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 15'h0010, '0);
    drive(1, 1'b1, 1'b0, 15'h0020, '0);
    for (int c = 0; c < 3; c++) begin
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (c_flags[d] !== 6'b0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d cyc%0d: got %b want 000000", d, c, c_flags[d]);
        end
      end
    end
    rst = 1'b0;
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_flags[d][5:4] !== 2'b10) begin
        errors++;
        $display("FAIL reset_first_gnt dut%0d: got %b want 10", d, c_flags[d][5:4]);
      end
      checks++;
      if (o_full[d] !== e_full[d]) begin
        errors++;
        $display("FAIL reset_model dut%0d: got %h want %h", d, o_full[d], e_full[d]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    advance();
  endtask

  task automatic test_single_port();
    drive(1, 1'b1, 1'b1, 15'h7FFF, 20'h0ABCD);
    advance();
    drive(1, 1'b1, 1'b0, 15'h7FFF, '0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_flags[d] !== 6'b010010) begin
        errors++;
        $display("FAIL single_write dut%0d: got %b want 010010", d, c_flags[d]);
      end
    end
    advance();
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_flags[d] !== 6'b010001) begin
        errors++;
        $display("FAIL single_read dut%0d: got %b want 010001", d, c_flags[d]);
      end
    end
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({c_flags[d][3:2], c_rdata[d]} !== {2'b01, 20'h0ABCD}) begin
        errors++;
        $display("FAIL single_return dut%0d: got rv=%b rdata=%h want rv=01 rdata=0abcd",
                 d, c_flags[d][3:2], c_rdata[d]);
      end
    end
  endtask

  task automatic test_round_robin();
    // Load the two words through the ports, then contend with reads.
    drive(0, 1'b1, 1'b1, 15'h0001, 20'h11111);
    advance();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b1, 15'h0002, 20'h22222);
    advance();
    drive(0, 1'b1, 1'b0, 15'h0001, '0);
    drive(1, 1'b1, 1'b0, 15'h0002, '0);
    for (int c = 0; c < 6; c++) begin
      logic [1:0] prev_g;
      prev_g = c_flags[0][5:4];
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_full[d] !== e_full[d]) begin
          errors++;
          $display("FAIL rr_model dut%0d cyc%0d: got %h want %h", d, c, o_full[d], e_full[d]);
        end
      end
      checks++;
      if (c_flags[0][5:4] !== (c % 2 == 0 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_alternate cyc%0d: got %b want %b (prev %b)", c, c_flags[0][5:4],
                 (c % 2 == 0) ? 2'b10 : 2'b01, prev_g);
      end
      if (c > 0) begin
        checks++;
        if ({c_flags[0][3:2], c_rdata[0]} !==
            ((c % 2 == 1) ? {2'b10, 20'h11111} : {2'b01, 20'h22222})) begin
          errors++;
          $display("FAIL rr_rdata cyc%0d: got rv=%b rdata=%h", c, c_flags[0][3:2], c_rdata[0]);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    drive(0, 1'b1, 1'b0, 15'h0001, '0);
    drive(1, 1'b1, 1'b0, 15'h0002, '0);
    for (int c = 0; c < 4; c++) begin
      advance();
      checks++;
      if (c_flags[1][5:4] !== 2'b10) begin
        errors++;
        $display("FAIL fp_p0_wins cyc%0d: got %b want 10", c, c_flags[1][5:4]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    advance();
    checks++;
    if (c_flags[1][5:4] !== 2'b01) begin
      errors++;
      $display("FAIL fp_p1_after_drop: got %b want 01", c_flags[1][5:4]);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    advance();
  endtask

  task automatic test_raw_cross_port();
    drive(0, 1'b1, 1'b1, 15'h0100, 20'h00005);
    advance();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 15'h0100, '0);
    advance();
    drive(1, 1'b0, 1'b0, '0, '0);
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({c_flags[d][3:2], c_rdata[d]} !== {2'b01, 20'h00005}) begin
        errors++;
        $display("FAIL raw_return dut%0d: got rv=%b rdata=%h want rv=01 rdata=00005",
                 d, c_flags[d][3:2], c_rdata[d]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1'b1, 1'b0, 15'h0100, '0);
    advance();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_flags[d] !== 6'b0) begin
        errors++;
        $display("FAIL midrst_during dut%0d: got %b want 000000", d, c_flags[d]);
      end
    end
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_flags[d][3:2] !== 2'b00) begin
        errors++;
        $display("FAIL midrst_no_rvalid dut%0d: got %b want 00", d, c_flags[d][3:2]);
      end
    end
    drive(0, 1'b1, 1'b0, 15'h0001, '0);
    drive(1, 1'b1, 1'b0, 15'h0002, '0);
    advance();
    checks++;
    if (c_flags[0][5:4] !== 2'b10) begin
      errors++;
      $display("FAIL midrst_ptr_reset: got %b want 10", c_flags[0][5:4]);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          // Pending requests keep their fields until granted.
          if (!(req[d][p] && !(e_any[d] && e_win[d] == p))) begin
            req[d][p]   = ($urandom_range(0, 3) != 0);
            we[d][p]    = $urandom_range(0, 1);
            addr[d][p]  = 15'($urandom_range(0, 7)) | (p == 1 ? 15'h4000 : 15'h0000)
                          ^ 15'($urandom_range(0, 1) << 14);
            wdata[d][p] = 20'($urandom);
          end
        end
      end
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_full[d] !== e_full[d]) begin
          errors++;
          $display("FAIL random_model dut%0d cyc%0d: got %h want %h", d, c, o_full[d], e_full[d]);
        end
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    advance();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1; m_rv[d] = 1'b0; m_rport[d] = 0; m_rdata[d] = '0;
      e_any[d] = 1'b0; e_win[d] = 0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
      end
    end
    test_reset();
    test_single_port();
    test_round_robin();
    test_fixed_priority();
    test_raw_cross_port();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bottom_mem_arbiter.md
Name: bottom_mem_arbiter

Overview:
- Two-port arbiter in front of the single-port 32K x 20-bit bottom memory.
- Port 0 is instruction fetch; port 1 is the load/store unit.
- Each cycle it grants at most one memory access, drives the memory control lines, and returns read data with a per-port valid.
- Arbitration is round-robin, or fixed priority to port 0, selected by parameter.

Parameters:
- DATA_W, 20: memory word width.
- ADDR_W, 15: memory address width (32768 words).
- RR_EN, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request; held with its fields until granted.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid on rdata.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid: same as port 0, for port 1.
- rdata  out  DATA_W  read data, shared by both ports; equals mem_do.
- mem_addr  out  ADDR_W  to memory addr.
- mem_di  out  DATA_W  to memory di.
- mem_we  out  1  to memory we.
- mem_re  out  1  to memory re.
- mem_do  in  DATA_W  from memory do (registered, 1-cycle read latency).

Behaviour:
- Single clock, synchronous active-high reset.
- Reset state: last-winner pointer = port 1, so port 0 wins the first conflict; read-return register cleared.
- Outputs while rst = 1: p0_gnt, p1_gnt, mem_we, mem_re, p0_rvalid, p1_rvalid all 0.
- Grant is combinational from req and the pointer:
  - One requester: it is granted.
  - Both requesting, RR_EN = 1: the port that did not win last grant is granted.
  - Both requesting, RR_EN = 0: port 0 is granted.
  - Neither requesting: no grant.
  - p0_gnt and p1_gnt are never both 1.
- Handshake: a request completes on the rising edge where req = 1 and gnt = 1.
  - Requester must hold we, addr and wdata stable while req = 1 and gnt = 0.
  - Requester may drop req, or present a new request, in the cycle after the grant.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Memory drive (combinational from the winner):
  - mem_addr = winner addr; mem_di = winner wdata.
  - mem_we = gnt & we; mem_re = gnt & ~we.
  - With no grant: mem_we = mem_re = 0; mem_addr and mem_di hold the port 0 fields (don't care).
- Pointer updates only on a cycle with a grant, and records the winner.
- Read return:
  - On a granted read at edge N, the arbiter registers the port id and a pending flag.
  - During cycle N+1, that port's rvalid = 1 and rdata = mem_do.
  - Pending is cleared or reloaded every cycle, so rvalid is a single-cycle pulse.
  - Reads are fully pipelined: reads granted on consecutive edges give consecutive rvalid pulses, possibly alternating ports.
- Writes: no response. A write at edge N is visible to a read granted at edge N+1 or later.
- Read and write in the same cycle is impossible (single winner).
- Reset mid-operation: a read granted at the edge where rst is sampled high produces no rvalid. Pending read data is discarded and the pointer returns to its reset value.
- Port fields outside the granted port are ignored. No address range checking (full 15-bit space).

Test Plan:
- Reset: hold rst 3 cycles with p0_req = p1_req = 1 -> all gnt/rvalid/mem_we/mem_re = 0. First cycle after release: p0_gnt = 1.
- Single port: p1 writes 0x0ABCD to addr 0x7FFF, then reads addr 0x7FFF -> p1_gnt each cycle; p1_rvalid = 1 one cycle after the read grant with rdata = 0x0ABCD; p0_rvalid stays 0.
- Round-robin contention: both ports request reads for 6 cycles (p0 addr 0x0001, p1 addr 0x0002; preloaded with 0x11111 and 0x22222) -> grants alternate p0,p1,p0,...; rvalid alternates with matching data 0x11111 / 0x22222.
- Fixed priority: RR_EN = 0, both requesting for 4 cycles -> p0_gnt = 1 every cycle, p1_gnt = 0. Drop p0_req -> p1 granted the same cycle.
- Read-after-write across ports: p0 writes 0x00005 to addr 0x0100 granted at edge N; p1 reads 0x0100 granted at edge N+1 -> p1_rvalid at cycle N+2 with rdata = 0x00005.
- Reset mid-read: p0 read granted on the same edge rst is sampled high -> p0_rvalid stays 0 next cycle. After rst low, a contention cycle grants p0 first.
